fp_mul_seq: RTL and testbench



---
 rtl/fpmul_pkg.sv | 38 +++
 rtl/fp_mant_mul_seq.sv | 53 +++++
 rtl/fp_mul_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// Shared types and constants for the sequential floating-point multiplier.
package fpmul_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  typedef enum logic [2:0] {CLS_NORM, CLS_ZERO, CLS_DNF, CLS_INF, CLS_NAN} op_class_e;

  localparam int unsigned FLAG_ZF   = 0;
  localparam int unsigned FLAG_DNF  = 1;
  localparam int unsigned FLAG_INF  = 2;
  localparam int unsigned FLAG_NANF = 3;
  localparam int unsigned FLAG_UF   = 4;
  localparam int unsigned FLAG_OF   = 5;
  localparam int unsigned FLAG_W    = 6;

  localparam int unsigned MAX_FMT_W = 128;

  function automatic op_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic frac_nz);
    if (exp_ones) return frac_nz ? CLS_NAN : CLS_INF;
    if (exp_zero) return frac_nz ? CLS_DNF : CLS_ZERO;
    return CLS_NORM;
  endfunction

  // Canonical quiet NaN, right-aligned in a MAX_FMT_W vector; callers slice to their width.
  function automatic logic [MAX_FMT_W-1:0] canon_qnan(input int unsigned exp_w,
                                                      input int unsigned man_w);
    logic [MAX_FMT_W-1:0] one;
    one = MAX_FMT_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mant_mul_seq.sv
// Iterative W x W shift-add multiplier: one multiplier bit per cycle, W cycles after i_start.
module fp_mant_mul_seq
  import fpmul_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_last,
  output logic [2*W-1:0] o_prod
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_prod;
  logic [W-1:0]   r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic           r_busy;
  logic           w_last;

  // High during the final iteration; o_prod is complete from the following cycle.
  assign w_last = r_busy && (r_cnt == CNT_W'(W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{W{1'b0}}, i_a};
      r_prod   <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign o_last = w_last;
  assign o_prod = r_prod;

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle parametrised FP multiplier with valid/ready handshake, RNE rounding and flags.
// Optional round-toward-zero mode (rm port) is enabled by defining FPMUL_RTZ_EN.
module fp_mul_seq
  import fpmul_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned BIAS  = 2**(EXP_W-1) - 1
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef FPMUL_RTZ_EN
  input  logic                   rm,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   p,
  output logic                   zf,
  output logic                   dnf,
  output logic                   inf,
  output logic                   nanf,
  output logic                   uf,
  output logic                   of
);

  localparam int unsigned W     = MAN_W + 1;
  localparam int unsigned FMT_W = 1 + EXP_W + MAN_W;
  localparam int unsigned E_W   = EXP_W + 2;
  localparam logic [MAX_FMT_W-1:0] QNAN_FULL = canon_qnan(EXP_W, MAN_W);
  localparam logic [FMT_W-1:0] QNAN = QNAN_FULL[FMT_W-1:0];
  localparam logic signed [E_W-1:0] EXP_OVF  = E_W'(2**EXP_W - 1);
  localparam logic signed [E_W-1:0] EXP_ZERO = '0;

  logic [2:0]              r_state;
  logic [FMT_W-1:0]        r_a, r_b, r_p;
  logic [FLAG_W-1:0]       r_flags;
  logic signed [E_W-1:0]   r_exp;
  logic                    r_sign;
  logic [MAN_W-1:0]        r_frac;
  logic                    r_guard, r_sticky;

  logic                    w_sa, w_sb, w_sign;
  logic [EXP_W-1:0]        w_ea, w_eb;
  logic [MAN_W-1:0]        w_fa, w_fb;
  op_class_e               w_ca, w_cb;
  logic                    w_any_nan, w_any_inf, w_any_zero, w_any_dnf;
  logic                    w_chk_special;
  logic [FMT_W-1:0]        w_chk_p;
  logic [FLAG_W-1:0]       w_chk_flags;
  logic signed [E_W-1:0]   w_exp_sum;
  logic                    w_mul_start, w_mul_last;
  logic [2*W-1:0]          w_prod;
  logic [MAN_W-1:0]        w_nfrac;
  logic                    w_nguard, w_nsticky;
  logic                    w_rtz, w_inc;
  logic [MAN_W:0]          w_rsum;
  logic signed [E_W-1:0]   w_rexp;
  logic                    w_round_ovf, w_round_unf;
  logic [FMT_W-1:0]        w_round_p;
  logic [FLAG_W-1:0]       w_round_flags;

  assign w_sa = r_a[FMT_W-1];
  assign w_sb = r_b[FMT_W-1];
  assign w_ea = r_a[FMT_W-2:MAN_W];
  assign w_eb = r_b[FMT_W-2:MAN_W];
  assign w_fa = r_a[MAN_W-1:0];
  assign w_fb = r_b[MAN_W-1:0];
  assign w_sign = w_sa ^ w_sb;

  assign w_ca = classify(&w_ea, ~|w_ea, |w_fa);
  assign w_cb = classify(&w_eb, ~|w_eb, |w_fb);
  assign w_any_nan  = (w_ca == CLS_NAN) || (w_cb == CLS_NAN);
  assign w_any_inf  = (w_ca == CLS_INF) || (w_cb == CLS_INF);
  assign w_any_dnf  = (w_ca == CLS_DNF) || (w_cb == CLS_DNF);
  assign w_any_zero = (w_ca == CLS_ZERO) || (w_cb == CLS_ZERO) || w_any_dnf;

  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(E_W'(BIAS));

  always_comb begin
    w_chk_special = 1'b1;
    w_chk_p       = '0;
    w_chk_flags   = '0;
    w_chk_flags[FLAG_DNF] = w_any_dnf;
    if (w_any_nan || (w_any_inf && w_any_zero)) begin
      w_chk_p = QNAN;
      w_chk_flags[FLAG_NANF] = 1'b1;
    end else if (w_any_inf) begin
      w_chk_p = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_chk_flags[FLAG_INF] = 1'b1;
    end else if (w_any_zero) begin
      w_chk_p = {w_sign, {(EXP_W + MAN_W){1'b0}}};
      w_chk_flags[FLAG_ZF] = 1'b1;
    end else begin
      w_chk_special = 1'b0;
    end
  end

  assign w_mul_start = (r_state == S_CHECK) && !w_chk_special;

  fp_mant_mul_seq #(
    .W (W)
  ) u_mant_mul (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_start (w_mul_start),
    .i_a     ({1'b1, w_fa}),
    .i_b     ({1'b1, w_fb}),
    .o_last  (w_mul_last),
    .o_prod  (w_prod)
  );

  // Product lies in [1,4); the hidden bit is either the MSB or the one just below it.
  always_comb begin
    if (w_prod[2*W-1]) begin
      w_nfrac   = w_prod[2*W-2:W];
      w_nguard  = w_prod[W-1];
      w_nsticky = |w_prod[W-2:0];
    end else begin
      w_nfrac   = w_prod[2*W-3:W-1];
      w_nguard  = w_prod[W-2];
      w_nsticky = |w_prod[W-3:0];
    end
  end

`ifdef FPMUL_RTZ_EN
  logic r_rm;
  assign w_rtz = r_rm;
`else
  assign w_rtz = 1'b0;
`endif

  // Hidden bit is always one, so a carry out of the fraction means mantissa 2.0 -> 1.0, e+1.
  assign w_inc  = !w_rtz && r_guard && (r_sticky || r_frac[0]);
  assign w_rsum = {1'b0, r_frac} + {{MAN_W{1'b0}}, w_inc};
  assign w_rexp = r_exp + $signed({{(E_W-1){1'b0}}, w_rsum[MAN_W]});
  assign w_round_ovf = (w_rexp >= EXP_OVF);
  assign w_round_unf = (w_rexp <= EXP_ZERO);

  always_comb begin
    w_round_p     = {r_sign, w_rexp[EXP_W-1:0], w_rsum[MAN_W-1:0]};
    w_round_flags = '0;
    if (w_round_ovf) begin
      w_round_flags[FLAG_OF] = 1'b1;
      if (w_rtz) begin
        w_round_p = {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      end else begin
        w_round_p = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_round_flags[FLAG_INF] = 1'b1;
      end
    end else if (w_round_unf) begin
      w_round_p = {r_sign, {(EXP_W + MAN_W){1'b0}}};
      w_round_flags[FLAG_UF] = 1'b1;
      w_round_flags[FLAG_ZF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_flags  <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_frac   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
`ifdef FPMUL_RTZ_EN
      r_rm     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
`ifdef FPMUL_RTZ_EN
            r_rm    <= rm;
`endif
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_sign <= w_sign;
          r_exp  <= w_exp_sum;
          if (w_chk_special) begin
            r_p     <= w_chk_p;
            r_flags <= w_chk_flags;
            r_state <= S_OUT;
          end else begin
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          if (w_mul_last) r_state <= S_NORM;
        end
        S_NORM: begin
          r_frac   <= w_nfrac;
          r_guard  <= w_nguard;
          r_sticky <= w_nsticky;
          r_exp    <= r_exp + $signed({{(E_W-1){1'b0}}, w_prod[2*W-1]});
          r_state  <= S_ROUND;
        end
        S_ROUND: begin
          r_p     <= w_round_p;
          r_flags <= w_round_flags;
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign p    = r_p;
  assign zf   = r_flags[FLAG_ZF];
  assign dnf  = r_flags[FLAG_DNF];
  assign inf  = r_flags[FLAG_INF];
  assign nanf = r_flags[FLAG_NANF];
  assign uf   = r_flags[FLAG_UF];
  assign of   = r_flags[FLAG_OF];

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq at single precision (EXP_W=8, MAN_W=23).
module tb_fp_mul_seq;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_ZF   = 6'b100000;
  localparam logic [5:0] F_DNF  = 6'b010000;
  localparam logic [5:0] F_INF  = 6'b001000;
  localparam logic [5:0] F_NAN  = 6'b000100;
  localparam logic [5:0] F_UF   = 6'b000010;
  localparam logic [5:0] F_OF   = 6'b000001;
  localparam int LAT_NORM = 27;
  localparam int LAT_SPEC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid;
  logic [31:0] p;
  logic        zf, dnf, inf, nanf, uf, of;
  logic [5:0]  flags;
`ifdef FPMUL_RTZ_EN
  logic        rm = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [37:0] sb_q[$];

  assign flags = {zf, dnf, inf, nanf, uf, of};

  always #5 clk = ~clk;

  fp_mul_seq u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FPMUL_RTZ_EN
    .rm        (rm),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .zf        (zf),
    .dnf       (dnf),
    .inf       (inf),
    .nanf      (nanf),
    .uf        (uf),
    .of        (of)
  );

  // Reference: exact product in double precision, then RNE down to single.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    real         rx, ry;
    logic [10:0] ex, ey;
    logic [63:0] d;
    logic [23:0] fr;
    int          e;
    ex = {3'b000, x[30:23]} + 11'd896;
    ey = {3'b000, y[30:23]} + 11'd896;
    rx = $bitstoreal({x[31], ex, x[22:0], 29'd0});
    ry = $bitstoreal({y[31], ey, y[22:0], 29'd0});
    d  = $realtobits(rx * ry);
    e  = int'(d[62:52]) - 896;
    fr = {1'b0, d[51:29]} + 24'(d[28] & ((|d[27:0]) | d[29]));
    if (fr[23]) e = e + 1;
    return {d[63], e[7:0], fr[22:0]};
  endfunction

  task automatic accept_op(input string name, input logic [31:0] xa, xb, ep,
                           input logic [5:0] ef);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_accept: in_ready=%b, required 1", name, in_ready);
    end
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back({ep, ef});
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, lat);
    end
  endtask

  task automatic drain_check(input string name);
    logic [37:0] exp_v;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s_sb: scoreboard empty, required one pending result", name);
    end else begin
      exp_v = sb_q.pop_front();
      if ({p, flags} !== exp_v) begin
        n_errors++;
        $display("FAIL %s: p=%h flags=%b, required p=%h flags=%b", name, p, flags,
                 exp_v[37:6], exp_v[5:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] xa, xb, ep,
                        input logic [5:0] ef, input int elat);
    int lat;
    accept_op(name, xa, xb, ep, ef);
    wait_out(name, lat);
    n_checks++;
    if (lat !== elat) begin
      n_errors++;
      $display("FAIL %s_latency: %0d cycles, required %0d", name, lat, elat);
    end
    drain_check(name);
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== 32'h0 || flags !== F_NONE) begin
      n_errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b p=%h flags=%b, required 1 0 0 000000",
               in_ready, out_valid, p, flags);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_normal;
    run_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, F_NONE, LAT_NORM);
    run_op("rne_sticky",  32'h3F800001, 32'h3F800001, 32'h3F800002, F_NONE, LAT_NORM);
    run_op("neg_sign",    32'hC0000000, 32'h3FC00000, 32'hC0400000, F_NONE, LAT_NORM);
    run_op("norm_shift",  32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, F_NONE, LAT_NORM);
    run_op("tie_odd_up",  32'h3FC00000, 32'h3F800001, 32'h3FC00002, F_NONE, LAT_NORM);
    run_op("tie_even",    32'h3FC00000, 32'h3F800003, 32'h3FC00004, F_NONE, LAT_NORM);
`ifdef FPMUL_RTZ_EN
    rm = 1'b1;
    run_op("rtz_sticky",  32'h3F800001, 32'h3F800001, 32'h3F800002, F_NONE, LAT_NORM);
    run_op("rtz_tie",     32'h3FC00000, 32'h3F800001, 32'h3FC00001, F_NONE, LAT_NORM);
    run_op("rtz_ovf",     32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, F_OF, LAT_NORM);
    rm = 1'b0;
`endif
  endtask

  task automatic test_special;
    run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, F_NAN, LAT_SPEC);
    run_op("ninf_x_2",    32'hFF800000, 32'h40000000, 32'hFF800000, F_INF, LAT_SPEC);
    run_op("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_NAN, LAT_SPEC);
    run_op("inf_x_dnf",   32'h7F800000, 32'h00000001, 32'h7FC00000, F_NAN | F_DNF, LAT_SPEC);
    run_op("nzero_x_1",   32'h80000000, 32'h3F800000, 32'h80000000, F_ZF, LAT_SPEC);
    run_op("dnf_x_1",     32'h00000001, 32'h3F800000, 32'h00000000, F_ZF | F_DNF, LAT_SPEC);
  endtask

  task automatic test_over_under;
    run_op("ovf",         32'h7F000000, 32'h7F000000, 32'h7F800000, F_OF | F_INF, LAT_NORM);
    run_op("ovf_edge",    32'h7F000000, 32'h40000000, 32'h7F800000, F_OF | F_INF, LAT_NORM);
    run_op("max_exp_ok",  32'h7E800000, 32'h40000000, 32'h7F000000, F_NONE, LAT_NORM);
    run_op("neg_ovf",     32'hFF000000, 32'h7F000000, 32'hFF800000, F_OF | F_INF, LAT_NORM);
    run_op("unf",         32'h00800000, 32'h00800000, 32'h00000000, F_UF | F_ZF, LAT_NORM);
    run_op("unf_edge",    32'h00800000, 32'h3F000000, 32'h00000000, F_UF | F_ZF, LAT_NORM);
    run_op("min_exp_ok",  32'h00800000, 32'h3F800000, 32'h00800000, F_NONE, LAT_NORM);
  endtask

  task automatic test_backpressure;
    int lat;
    accept_op("bp", 32'h3FC00000, 32'h40000000, 32'h40400000, F_NONE);
    wait_out("bp", lat);
    for (int i = 0; i < 10; i++) begin
      a = 32'h40000000;
      b = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || p !== 32'h40400000 || flags !== F_NONE) begin
        n_errors++;
        $display("FAIL bp_hold: out_valid=%b p=%h flags=%b, required 1 40400000 000000",
                 out_valid, p, flags);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_in_ready: in_ready=%b, required 0", in_ready);
      end
    end
    in_valid = 1'b0;
    drain_check("bp_drain");
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_after_drain: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    accept_op("mid_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, F_NONE);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== 32'h0 || flags !== F_NONE) begin
      n_errors++;
      $display("FAIL mid_rst: out_valid=%b in_ready=%b p=%h flags=%b, required 0 1 0 000000",
               out_valid, in_ready, p, flags);
    end
    sb_q.delete();
    @(posedge clk); #3;
    rst = 1'b1;
    run_op("after_rst", 32'h3F800001, 32'h3F800001, 32'h3F800002, F_NONE, LAT_NORM);
  endtask

  task automatic test_back_to_back;
    int unsigned s, ex, fr;
    logic [31:0] xa, xb;
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(0, 1);
      ex = $urandom_range(100, 150);
      fr = $urandom_range(0, 32'h007FFFFF);
      xa = {s[0], ex[7:0], fr[22:0]};
      s = $urandom_range(0, 1);
      ex = $urandom_range(100, 150);
      fr = $urandom_range(0, 32'h007FFFFF);
      xb = {s[0], ex[7:0], fr[22:0]};
      run_op("b2b_rand", xa, xb, ref_mul(xa, xb), F_NONE, LAT_NORM);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_over_under();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d pending results, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
